garbage_queue: RTL and testbench

GARBAGE_QUEUE -- requirements
Module: garbage_queue

---
 rtl/garbage_pkg.sv | 54 +++++
 rtl/garbage_fifo.sv | 62 ++++++
 rtl/garbage_queue.sv | 166 ++++++++++++++++
 tb/tb_garbage_queue.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/garbage_pkg.sv
// Shared game-state encodings and the garbage queue package (entry type, depths, attack table).
// Optional build macro GARBAGE_CANCEL_EN selects the CANCEL state (see garbage_queue.sv).

`ifndef GAME_STATE_DEFINES
`define GAME_STATE_DEFINES
`define GS_NOTH 3'd0
`define GS_PREP 3'd1
`define GS_DROP 3'd2
`define GS_LKDY 3'd3
`define GS_PLAC 3'd4
`define GS_ELIM 3'd5
`define GS_GARB 3'd6
`define GS_LOSE 3'd7
`endif

package garbage_pkg;

    localparam int FIFO_DEPTH = 8;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = PTR_W + 1;

    localparam logic [3:0] INSERT_CAP = 4'd8;
    localparam logic [3:0] MAX_HOLE   = 4'd9;

    typedef struct packed {
        logic [2:0] lines;
        logic [3:0] hole;
    } garb_entry_t;

`ifdef GARBAGE_CANCEL_EN
    typedef enum logic [1:0] {
        Q_IDLE   = 2'd0,
        Q_CANCEL = 2'd1,
        Q_SEND   = 2'd2,
        Q_INSERT = 2'd3
    } q_state_t;
`else
    typedef enum logic [1:0] {
        Q_IDLE   = 2'd0,
        Q_SEND   = 2'd2,
        Q_INSERT = 2'd3
    } q_state_t;
`endif

    // Lines sent to the opponent for 0..4 rows cleared.
    localparam logic [4:0][2:0] ATTACK_TABLE = {3'd4, 3'd2, 3'd1, 3'd0, 3'd0};

    function automatic logic [2:0] attack_of(input logic [2:0] rows);
        logic [2:0] idx;
        idx = (rows > 3'd4) ? 3'd4 : rows;
        return ATTACK_TABLE[idx];
    endfunction

endpackage

// File: rtl/garbage_fifo.sv
// Eight-entry garbage FIFO with head line-count write-back and synchronous flush.

module garbage_fifo
    import garbage_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  garb_entry_t       push_data,
    input  logic              pop,
    input  logic              head_wr,
    input  logic [2:0]        head_lines,
    input  logic              flush,
    output garb_entry_t       head,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    garb_entry_t       mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic              push_en;
    logic              pop_en;
    logic              wr_en;

    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;
    assign wr_en   = head_wr && !empty && !pop_en;

    // Push never targets the head slot while it is live: the pointers only
    // coincide when empty (no head access) or full (no push).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end else if (wr_en) begin
                mem[rd_ptr].lines <= head_lines;
            end
            count <= count + CNT_W'(push_en) - CNT_W'(pop_en);
        end
    end

endmodule

// File: rtl/garbage_queue.sv
// Garbage line queue: buffers incoming attacks, cancels them with our clears, inserts rows in GARB.
// Build macro GARBAGE_CANCEL_EN enables the CANCEL state; without it every attack is sent in full.

module garbage_queue
    import garbage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  state,
    input  logic [4:0]  ctr_garb,
    input  logic        gin_valid,
    output logic        gin_ready,
    input  logic [2:0]  gin_lines,
    input  logic [3:0]  gin_hole,
    input  logic        clr_valid,
    input  logic [2:0]  clr_lines,
    output logic        row_ins,
    output logic [3:0]  row_hole,
    output logic        send_valid,
    output logic [2:0]  send_lines,
    output logic [5:0]  pending,
    output logic        busy
);

    q_state_t          fsm;
    q_state_t          fsm_n;
    logic [2:0]        residual;
    logic [2:0]        residual_n;
    logic [3:0]        ins_cnt;
    logic [3:0]        ins_cnt_n;

    garb_entry_t       head;
    garb_entry_t       push_data;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  count;

    logic              in_noth;
    logic              in_garb;
    logic [2:0]        attack;
    logic              push_store;
    logic              consume;
    logic              pop;
    logic              head_wr;
    logic              drains;

    assign in_noth   = (state == `GS_NOTH);
    assign in_garb   = (state == `GS_GARB);
    assign attack    = attack_of(clr_lines);
    assign gin_ready = !full;

    // Zero-line attacks are handshaken but never occupy a slot.
    assign push_store      = gin_valid && !full && (gin_lines != 3'd0) && !in_noth;
    assign push_data.lines = gin_lines;
    assign push_data.hole  = (gin_hole > MAX_HOLE) ? 4'd0 : gin_hole;

    assign pop     = consume && (head.lines == 3'd1);
    assign head_wr = consume && (head.lines != 3'd1);
    assign drains  = pop && (count == CNT_W'(1)) && !push_store;

    garbage_fifo u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push_store),
        .push_data  (push_data),
        .pop        (pop),
        .head_wr    (head_wr),
        .head_lines (head.lines - 3'd1),
        .flush      (in_noth),
        .head       (head),
        .full       (full),
        .empty      (empty),
        .count      (count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm      <= Q_IDLE;
            residual <= '0;
            ins_cnt  <= '0;
        end else begin
            fsm      <= fsm_n;
            residual <= residual_n;
            ins_cnt  <= ins_cnt_n;
        end
    end

    always_comb begin
        fsm_n      = fsm;
        residual_n = residual;
        ins_cnt_n  = ins_cnt;
        consume    = 1'b0;
        row_ins    = 1'b0;
        send_valid = 1'b0;
        if (in_noth) begin
            fsm_n      = Q_IDLE;
            residual_n = '0;
            ins_cnt_n  = '0;
        end else begin
            case (fsm)
                Q_IDLE: begin
                    if (clr_valid && (attack != 3'd0)) begin
                        residual_n = attack;
`ifdef GARBAGE_CANCEL_EN
                        fsm_n = empty ? Q_SEND : Q_CANCEL;
`else
                        fsm_n = Q_SEND;
`endif
                    end else if (in_garb && (ctr_garb == 5'd0) && !empty) begin
                        fsm_n     = Q_INSERT;
                        ins_cnt_n = '0;
                    end
                end
`ifdef GARBAGE_CANCEL_EN
                Q_CANCEL: begin
                    if ((residual != 3'd0) && !empty) begin
                        consume    = 1'b1;
                        residual_n = residual - 3'd1;
                        if (residual == 3'd1) begin
                            fsm_n = Q_IDLE;
                        end else if (drains) begin
                            fsm_n = Q_SEND;
                        end
                    end else begin
                        fsm_n = (residual != 3'd0) ? Q_SEND : Q_IDLE;
                    end
                end
`endif
                Q_SEND: begin
                    send_valid = 1'b1;
                    residual_n = '0;
                    fsm_n      = Q_IDLE;
                end
                Q_INSERT: begin
                    // Exit checks come first so a GARB phase ending mid-insert emits no row.
                    if (empty || (ins_cnt == INSERT_CAP) || !in_garb) begin
                        fsm_n = Q_IDLE;
                    end else begin
                        row_ins   = 1'b1;
                        consume   = 1'b1;
                        ins_cnt_n = ins_cnt + 4'd1;
                        if (drains || (ins_cnt_n == INSERT_CAP)) begin
                            fsm_n = Q_IDLE;
                        end
                    end
                end
                default: fsm_n = Q_IDLE;
            endcase
        end
    end

    assign row_hole   = row_ins ? head.hole : 4'd0;
    assign send_lines = send_valid ? residual : 3'd0;
    assign busy       = (fsm != Q_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= '0;
        end else if (in_noth) begin
            pending <= '0;
        end else begin
            pending <= pending + (push_store ? {3'b000, gin_lines} : 6'd0) - {5'b00000, consume};
        end
    end

endmodule

// File: tb/tb_garbage_queue.sv
// Directed self-checking bench for garbage_queue; expectations follow GARBAGE_CANCEL_EN.
`timescale 1ns/1ps

module tb_garbage_queue;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] state = `GS_PLAC;
    logic [4:0] ctr_garb = '0;
    logic       gin_valid = 1'b0;
    logic       gin_ready;
    logic [2:0] gin_lines = '0;
    logic [3:0] gin_hole = '0;
    logic       clr_valid = 1'b0;
    logic [2:0] clr_lines = '0;
    logic       row_ins;
    logic [3:0] row_hole;
    logic       send_valid;
    logic [2:0] send_lines;
    logic [5:0] pending;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    garbage_queue dut (
        .clk        (clk),
        .rst        (rst),
        .state      (state),
        .ctr_garb   (ctr_garb),
        .gin_valid  (gin_valid),
        .gin_ready  (gin_ready),
        .gin_lines  (gin_lines),
        .gin_hole   (gin_hole),
        .clr_valid  (clr_valid),
        .clr_lines  (clr_lines),
        .row_ins    (row_ins),
        .row_hole   (row_hole),
        .send_valid (send_valid),
        .send_lines (send_lines),
        .pending    (pending),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] l, input logic [3:0] h);
        gin_valid = 1'b1;
        gin_lines = l;
        gin_hole  = h;
        step();
        gin_valid = 1'b0;
        gin_lines = '0;
        gin_hole  = '0;
    endtask

    task automatic flush_q();
        state = `GS_NOTH;
        step();
        state = `GS_PLAC;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        n_tests++;
        if (pending !== 6'd0 || busy !== 1'b0 || row_ins !== 1'b0 || row_hole !== 4'd0 ||
            send_valid !== 1'b0 || send_lines !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: pending=%0d busy=%b row_ins=%b row_hole=%0d send_valid=%b send_lines=%0d, required all zero",
                     pending, busy, row_ins, row_hole, send_valid, send_lines);
        end
        rst = 1'b1;
        step();
        n_tests++;
        if (gin_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: gin_ready=%b busy=%b, required 1 0", gin_ready, busy);
        end
    endtask

    task automatic test_insert();
        logic [5:0] ins_exp;
        logic [5:0] pend_exp [6];
        ins_exp = 6'b001110;
        pend_exp = '{6'd3, 6'd3, 6'd2, 6'd1, 6'd0, 6'd0};
        flush_q();
        push(3'd3, 4'd4);
        n_tests++;
        if (pending !== 6'd3) begin
            n_fail++;
            $display("FAIL insert_push_pending: got %0d required 3", pending);
        end
        state = `GS_GARB;
        for (int k = 0; k < 6; k++) begin
            ctr_garb = 5'(k);
            #1;
            n_tests++;
            if (row_ins !== ins_exp[k] || (ins_exp[k] && row_hole !== 4'd4) || pending !== pend_exp[k]) begin
                n_fail++;
                $display("FAIL insert_cycle%0d: row_ins=%b row_hole=%0d pending=%0d, required %b 4 %0d",
                         k, row_ins, row_hole, pending, ins_exp[k], pend_exp[k]);
            end
            step();
        end
        state = `GS_PLAC;
        ctr_garb = '0;
        n_tests++;
        if (busy !== 1'b0 || pending !== 6'd0) begin
            n_fail++;
            $display("FAIL insert_end: busy=%b pending=%0d, required 0 0", busy, pending);
        end
    endtask

    task automatic test_cancel();
`ifdef GARBAGE_CANCEL_EN
        logic [5:0] busy_exp;
        logic [5:0] pend_exp [6];
        busy_exp = 6'b011110;
        pend_exp = '{6'd5, 6'd5, 6'd4, 6'd3, 6'd2, 6'd1};
        flush_q();
        push(3'd2, 4'd1);
        push(3'd3, 4'd5);
        n_tests++;
        if (pending !== 6'd5) begin
            n_fail++;
            $display("FAIL cancel_setup_pending: got %0d required 5", pending);
        end
        for (int k = 0; k < 6; k++) begin
            clr_valid = (k == 0);
            clr_lines = 3'd4;
            #1;
            n_tests++;
            if (send_valid !== 1'b0 || busy !== busy_exp[k] || pending !== pend_exp[k]) begin
                n_fail++;
                $display("FAIL cancel_cycle%0d: send_valid=%b busy=%b pending=%0d, required 0 %b %0d",
                         k, send_valid, busy, pending, busy_exp[k], pend_exp[k]);
            end
            step();
        end
        clr_valid = 1'b0;
        clr_lines = '0;
        state = `GS_GARB;
        for (int k = 0; k < 4; k++) begin
            ctr_garb = 5'(k);
            #1;
            n_tests++;
            if (row_ins !== (k == 1) || (k == 1 && row_hole !== 4'd5)) begin
                n_fail++;
                $display("FAIL cancel_residue_cycle%0d: row_ins=%b row_hole=%0d, required %b 5",
                         k, row_ins, row_hole, (k == 1));
            end
            step();
        end
        state = `GS_PLAC;
        ctr_garb = '0;
        n_tests++;
        if (pending !== 6'd0) begin
            n_fail++;
            $display("FAIL cancel_residue_pending: got %0d required 0", pending);
        end
`else
        flush_q();
        push(3'd1, 4'd0);
        for (int k = 0; k < 4; k++) begin
            clr_valid = (k == 0);
            clr_lines = 3'd4;
            #1;
            n_tests++;
            if (send_valid !== (k == 1) || send_lines !== ((k == 1) ? 3'd4 : 3'd0) ||
                pending !== 6'd1 || row_ins !== 1'b0) begin
                n_fail++;
                $display("FAIL nocancel_cycle%0d: send_valid=%b send_lines=%0d pending=%0d row_ins=%b, required %b %0d 1 0",
                         k, send_valid, send_lines, pending, row_ins, (k == 1), (k == 1) ? 4 : 0);
            end
            step();
        end
        clr_valid = 1'b0;
        clr_lines = '0;
`endif
    endtask

    task automatic test_send();
        logic [2:0] clr_tab [3];
        logic [2:0] snd_tab [3];
        logic       exp_v;
        clr_tab = '{3'd3, 3'd1, 3'd7};
        snd_tab = '{3'd2, 3'd0, 3'd4};
        flush_q();
        for (int t = 0; t < 3; t++) begin
            for (int k = 0; k < 4; k++) begin
                clr_valid = (k == 0);
                clr_lines = clr_tab[t];
                exp_v = (k == 1) && (snd_tab[t] != 3'd0);
                #1;
                n_tests++;
                if (send_valid !== exp_v || send_lines !== (exp_v ? snd_tab[t] : 3'd0) ||
                    busy !== exp_v || row_ins !== 1'b0) begin
                    n_fail++;
                    $display("FAIL send_clr%0d_cycle%0d: send_valid=%b send_lines=%0d busy=%b row_ins=%b, required %b %0d %b 0",
                             clr_tab[t], k, send_valid, send_lines, busy, row_ins, exp_v,
                             exp_v ? snd_tab[t] : 3'd0, exp_v);
                end
                step();
            end
        end
        clr_valid = 1'b0;
        clr_lines = '0;
    endtask

    task automatic test_full();
        int rows;
        logic       exp_ins;
        logic [3:0] exp_hole;
        logic [5:0] exp_pend;
        flush_q();
        for (int i = 0; i < 8; i++) push(3'd7, 4'(i));
        n_tests++;
        if (gin_ready !== 1'b0 || pending !== 6'd56) begin
            n_fail++;
            $display("FAIL full_fill: gin_ready=%b pending=%0d, required 0 56", gin_ready, pending);
        end
        push(3'd7, 4'd9);
        n_tests++;
        if (pending !== 6'd56) begin
            n_fail++;
            $display("FAIL full_push_blocked: pending=%0d required 56", pending);
        end
        rows = 0;
        state = `GS_GARB;
        for (int k = 0; k < 11; k++) begin
            ctr_garb = 5'(k);
            exp_ins  = (k >= 1 && k <= 8);
            exp_hole = (k == 8) ? 4'd1 : 4'd0;
            exp_pend = (k <= 1) ? 6'd56 : ((k <= 9) ? 6'(57 - k) : 6'd48);
            #1;
            if (row_ins === 1'b1) rows++;
            n_tests++;
            if (row_ins !== exp_ins || (exp_ins && row_hole !== exp_hole) || pending !== exp_pend) begin
                n_fail++;
                $display("FAIL full_insert_cycle%0d: row_ins=%b row_hole=%0d pending=%0d, required %b %0d %0d",
                         k, row_ins, row_hole, pending, exp_ins, exp_hole, exp_pend);
            end
            step();
        end
        state = `GS_PLAC;
        ctr_garb = '0;
        n_tests++;
        if (rows != 8 || pending !== 6'd48 || gin_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL full_insert_end: rows=%0d pending=%0d gin_ready=%b busy=%b, required 8 48 1 0",
                     rows, pending, gin_ready, busy);
        end
        step();
        state = `GS_GARB;
        for (int k = 0; k < 3; k++) begin
            ctr_garb = 5'(k);
            #1;
            n_tests++;
            if (row_ins !== (k >= 1) || (k >= 1 && row_hole !== 4'd1)) begin
                n_fail++;
                $display("FAIL persist_cycle%0d: row_ins=%b row_hole=%0d, required %b 1",
                         k, row_ins, row_hole, (k >= 1));
            end
            step();
        end
        state = `GS_PLAC;
        ctr_garb = '0;
        step();
    endtask

    task automatic test_hole_zero();
        flush_q();
        push(3'd0, 4'd3);
        n_tests++;
        if (pending !== 6'd0 || gin_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_lines: pending=%0d gin_ready=%b busy=%b, required 0 1 0", pending, gin_ready, busy);
        end
        push(3'd2, 4'd12);
        n_tests++;
        if (pending !== 6'd2) begin
            n_fail++;
            $display("FAIL hole_push_pending: got %0d required 2", pending);
        end
        state = `GS_GARB;
        for (int k = 0; k < 5; k++) begin
            ctr_garb = 5'(k);
            #1;
            n_tests++;
            if (row_ins !== (k == 1 || k == 2) || row_hole !== 4'd0) begin
                n_fail++;
                $display("FAIL hole_clamp_cycle%0d: row_ins=%b row_hole=%0d, required %b 0",
                         k, row_ins, row_hole, (k == 1 || k == 2));
            end
            step();
        end
        state = `GS_PLAC;
        ctr_garb = '0;
        n_tests++;
        if (pending !== 6'd0) begin
            n_fail++;
            $display("FAIL hole_end_pending: got %0d required 0", pending);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] ins_exp;
        logic [3:0] hole_exp [6];
        logic [5:0] pend_exp [6];
        ins_exp  = 6'b001110;
        hole_exp = '{4'd0, 4'd3, 4'd3, 4'd6, 4'd0, 4'd0};
        pend_exp = '{6'd2, 6'd2, 6'd2, 6'd1, 6'd0, 6'd0};
        flush_q();
        push(3'd2, 4'd3);
        state = `GS_GARB;
        for (int k = 0; k < 6; k++) begin
            ctr_garb  = 5'(k);
            gin_valid = (k == 1);
            gin_lines = (k == 1) ? 3'd1 : 3'd0;
            gin_hole  = (k == 1) ? 4'd6 : 4'd0;
            clr_valid = (k == 2);
            clr_lines = 3'd4;
            #1;
            n_tests++;
            if (row_ins !== ins_exp[k] || row_hole !== hole_exp[k] || pending !== pend_exp[k] ||
                send_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_cycle%0d: row_ins=%b row_hole=%0d pending=%0d send_valid=%b, required %b %0d %0d 0",
                         k, row_ins, row_hole, pending, send_valid, ins_exp[k], hole_exp[k], pend_exp[k]);
            end
            step();
        end
        gin_valid = 1'b0;
        gin_lines = '0;
        gin_hole  = '0;
        clr_valid = 1'b0;
        clr_lines = '0;
        state = `GS_PLAC;
        ctr_garb = '0;
        #1;
        n_tests++;
        if (busy !== 1'b0 || pending !== 6'd0 || send_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_end: busy=%b pending=%0d send_valid=%b, required 0 0 0", busy, pending, send_valid);
        end
        step();
    endtask

    task automatic test_noth();
        flush_q();
        push(3'd5, 4'd7);
        state = `GS_GARB;
        ctr_garb = 5'd0;
        step();
        ctr_garb = 5'd1;
        #1;
        n_tests++;
        if (row_ins !== 1'b1 || row_hole !== 4'd7 || pending !== 6'd5) begin
            n_fail++;
            $display("FAIL noth_pre: row_ins=%b row_hole=%0d pending=%0d, required 1 7 5", row_ins, row_hole, pending);
        end
        step();
        state = `GS_NOTH;
        #1;
        n_tests++;
        if (row_ins !== 1'b0 || send_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL noth_same_cycle: row_ins=%b send_valid=%b, required 0 0", row_ins, send_valid);
        end
        step();
        state = `GS_PLAC;
        ctr_garb = '0;
        n_tests++;
        if (pending !== 6'd0 || busy !== 1'b0 || gin_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL noth_after: pending=%0d busy=%b gin_ready=%b, required 0 0 1", pending, busy, gin_ready);
        end
    endtask

    task automatic test_reset_mid();
        flush_q();
        push(3'd3, 4'd2);
        clr_valid = 1'b1;
        clr_lines = 3'd4;
        step();
        clr_valid = 1'b0;
        clr_lines = '0;
        #1;
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_busy: busy=%b required 1", busy);
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if (row_ins !== 1'b0 || row_hole !== 4'd0 || send_valid !== 1'b0 || send_lines !== 3'd0 ||
            busy !== 1'b0 || pending !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: row_ins=%b row_hole=%0d send_valid=%b send_lines=%0d busy=%b pending=%0d, required all zero",
                     row_ins, row_hole, send_valid, send_lines, busy, pending);
        end
        step();
        rst = 1'b1;
        step();
        #1;
        n_tests++;
        if (gin_ready !== 1'b1 || busy !== 1'b0 || pending !== 6'd0 || send_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_release: gin_ready=%b busy=%b pending=%0d send_valid=%b, required 1 0 0 0",
                     gin_ready, busy, pending, send_valid);
        end
    endtask

    initial begin
        test_reset();
        test_insert();
        test_cancel();
        test_send();
        test_full();
        test_hole_zero();
        test_back_to_back();
        test_noth();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
